// File: rtl/vga_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_scan_ctrl                                                   |
// | Purpose  : 640x480@60 VGA timing from a 50 MHz clock; scans a 128x96       |
// |            1-bit-per-plane framebuffer with SCALExSCALE replication and    |
// |            registers RGB/syncs so all pins line up with the 1-cycle RAM    |
// |            read latency.                                                   |
// | Options  : VGA_COLORBAR_EN - adds bar_sel input selecting an 8-bar test    |
// |            pattern derived from the column instead of VRAM data.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module vga_scan_ctrl #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int SCALE  = 5    // H_VIS must equal 128*SCALE, V_VIS 96*SCALE
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [13:0] vram_addr,
  output logic        vram_en,
  output logic        vram_we,
  input  logic        red_do,
  input  logic        grn_do,
  input  logic        blu_do,
`ifdef VGA_COLORBAR_EN
  input  logic        bar_sel,
`endif
  output logic        vga_r,
  output logic        vga_g,
  output logic        vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_st
);

  localparam int c_h_tot = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int c_v_tot = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(c_h_tot);
  localparam int VW      = $clog2(c_v_tot);
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

  logic          r_phase;
  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [SW-1:0] r_hsub;
  logic [SW-1:0] r_vsub;
  logic [6:0]    r_col;
  logic [6:0]    r_row;
  logic          r_hs_a;
  logic          r_vs_a;

  logic          w_tick;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_hsub_last;
  logic          w_vsub_last;
  logic          w_vis;
  logic          w_hs_raw;
  logic          w_vs_raw;
  logic          w_origin;
  logic [2:0]    w_pix;

  // The RAM port is read-only from this side.
  assign vram_we = 1'b0;

  assign w_tick      = r_phase;
  assign w_h_last    = (r_hcnt == HW'(c_h_tot - 1));
  assign w_v_last    = (r_vcnt == VW'(c_v_tot - 1));
  assign w_hsub_last = (r_hsub == SW'(SCALE - 1));
  assign w_vsub_last = (r_vsub == SW'(SCALE - 1));
  assign w_vis       = (r_hcnt < HW'(H_VIS)) && (r_vcnt < VW'(V_VIS));
  assign w_hs_raw    = ~((r_hcnt >= HW'(H_VIS + H_FP)) &&
                         (r_hcnt <  HW'(H_VIS + H_FP + H_SYNC)));
  assign w_vs_raw    = ~((r_vcnt >= VW'(V_VIS + V_FP)) &&
                         (r_vcnt <  VW'(V_VIS + V_FP + V_SYNC)));
  assign w_origin    = (r_hcnt == '0) && (r_vcnt == '0);

  // Pixel-rate phase: every second clk edge is a pixel tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_phase <= 1'b0;
    else        r_phase <= ~r_phase;
  end

  // Horizontal position, sub-pixel replication count and framebuffer column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt <= '0;
      r_hsub <= '0;
      r_col  <= '0;
    end else if (w_tick) begin
      if (w_h_last) begin
        r_hcnt <= '0;
        r_hsub <= '0;
        r_col  <= '0;
      end else begin
        r_hcnt <= r_hcnt + HW'(1);
        if (w_hsub_last) begin
          r_hsub <= '0;
          r_col  <= r_col + 7'd1;
        end else begin
          r_hsub <= r_hsub + SW'(1);
        end
      end
    end
  end

  // Vertical position, line replication count and framebuffer row; step on line wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vcnt <= '0;
      r_vsub <= '0;
      r_row  <= '0;
    end else if (w_tick && w_h_last) begin
      if (w_v_last) begin
        r_vcnt <= '0;
        r_vsub <= '0;
        r_row  <= '0;
      end else begin
        r_vcnt <= r_vcnt + VW'(1);
        if (w_vsub_last) begin
          r_vsub <= '0;
          r_row  <= r_row + 7'd1;
        end else begin
          r_vsub <= r_vsub + SW'(1);
        end
      end
    end
  end

  // Stage A: present the address for the current position; the address only
  // moves on visible pixels so the bus never leaves the 0..12287 window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_addr <= '0;
      vram_en   <= 1'b0;
      r_hs_a    <= 1'b1;
      r_vs_a    <= 1'b1;
      frame_st  <= 1'b0;
    end else begin
      frame_st <= w_tick & w_origin;
      if (w_tick) begin
        vram_en <= w_vis;
        r_hs_a  <= w_hs_raw;
        r_vs_a  <= w_vs_raw;
        if (w_vis) vram_addr <= {r_row, r_col};
      end
    end
  end

`ifdef VGA_COLORBAR_EN
  logic [2:0] r_col_hi_a;
  logic       r_bar_a;

  // Stage A companion for the test pattern: capture column MSBs and the selector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_hi_a <= '0;
      r_bar_a    <= 1'b0;
    end else if (w_tick) begin
      r_col_hi_a <= r_col[6:4];
      r_bar_a    <= bar_sel;
    end
  end

  assign w_pix = r_bar_a ? ~r_col_hi_a : {red_do, grn_do, blu_do};
`else
  assign w_pix = {red_do, grn_do, blu_do};
`endif

  // Stage B: drive pins one tick after stage A; vram_en doubles as the
  // stage-A visibility flag so blanking forces black.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r <= 1'b0;
      vga_g <= 1'b0;
      vga_b <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (w_tick) begin
      {vga_r, vga_g, vga_b} <= vram_en ? w_pix : 3'b000;
      hsync <= r_hs_a;
      vsync <= r_vs_a;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vga_scan_ctrl                                                |
// | Purpose  : Self-checking bench for vga_scan_ctrl: a full-size instance     |
// |            with a one-pixel red RAM image and a shrunken-timing instance   |
// |            with all-ones RAM for frame-level behaviour.                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_vga_scan_ctrl;

  typedef struct packed {
    int hvis; int hfp; int hsw; int hbp;
    int vvis; int vfp; int vsw; int vbp;
    int scale;
  } cfg_t;

  typedef struct packed {
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;

  typedef struct packed {
    int h;
    int v;
    int addr;
    bit en;
  } vec_t;

  cfg_t ca;
  cfg_t cb;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;

  // instance A (full timing)
  logic [13:0] addr_a;
  logic        en_a, we_a, vr_a, vg_a, vb_a, hs_a, vs_a, fs_a;
  logic        r_do_a = 1'b0, g_do_a = 1'b0, b_do_a = 1'b0;
  // instance B (shrunken timing, SCALE 1)
  logic [13:0] addr_b;
  logic        en_b, we_b, vr_b, vg_b, vb_b, hs_b, vs_b, fs_b;
  logic        r_do_b = 1'b0, g_do_b = 1'b0, b_do_b = 1'b0;
`ifdef VGA_COLORBAR_EN
  logic        bar_a = 1'b0;
  logic        bar_b = 1'b0;
`endif

  vga_scan_ctrl u_dut_a (
    .clk       (clk),
    .rst_n     (rst_a_n),
    .vram_addr (addr_a),
    .vram_en   (en_a),
    .vram_we   (we_a),
    .red_do    (r_do_a),
    .grn_do    (g_do_a),
    .blu_do    (b_do_a),
`ifdef VGA_COLORBAR_EN
    .bar_sel   (bar_a),
`endif
    .vga_r     (vr_a),
    .vga_g     (vg_a),
    .vga_b     (vb_a),
    .hsync     (hs_a),
    .vsync     (vs_a),
    .frame_st  (fs_a)
  );

  vga_scan_ctrl #(
    .H_VIS(128), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_VIS(96),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SCALE(1)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_b_n),
    .vram_addr (addr_b),
    .vram_en   (en_b),
    .vram_we   (we_b),
    .red_do    (r_do_b),
    .grn_do    (g_do_b),
    .blu_do    (b_do_b),
`ifdef VGA_COLORBAR_EN
    .bar_sel   (bar_b),
`endif
    .vga_r     (vr_b),
    .vga_g     (vg_b),
    .vga_b     (vb_b),
    .hsync     (hs_b),
    .vsync     (vs_b),
    .frame_st  (fs_b)
  );

  // Behavioural RAMs: 1-clk read latency, output held while enable is low.
  always @(posedge clk) begin
    if (en_a) begin
      r_do_a <= (addr_a == 14'd0);
      g_do_a <= 1'b0;
      b_do_a <= 1'b0;
    end
    if (en_b) begin
      r_do_b <= 1'b1;
      g_do_b <= 1'b1;
      b_do_b <= 1'b1;
    end
  end

  // Clock edges seen since each reset release.
  int na, nb;
  always @(posedge clk or negedge rst_a_n) if (!rst_a_n) na <= 0; else na <= na + 1;
  always @(posedge clk or negedge rst_b_n) if (!rst_b_n) nb <= 0; else nb <= nb + 1;

  // ---------------- reference model ----------------
  function automatic int ht(cfg_t c); return c.hvis + c.hfp + c.hsw + c.hbp; endfunction
  function automatic int vt(cfg_t c); return c.vvis + c.vfp + c.vsw + c.vbp; endfunction
  function automatic int hp(cfg_t c, int k); return k % ht(c); endfunction
  function automatic int vp(cfg_t c, int k); return (k / ht(c)) % vt(c); endfunction
  function automatic bit vis(cfg_t c, int k);
    return (hp(c, k) < c.hvis) && (vp(c, k) < c.vvis);
  endfunction
  function automatic bit hsr(cfg_t c, int k);
    int h;
    h = hp(c, k);
    return !((h >= c.hvis + c.hfp) && (h < c.hvis + c.hfp + c.hsw));
  endfunction
  function automatic bit vsr(cfg_t c, int k);
    int v;
    v = vp(c, k);
    return !((v >= c.vvis + c.vfp) && (v < c.vvis + c.vfp + c.vsw));
  endfunction
  function automatic int adr(cfg_t c, int k);
    return (vp(c, k) / c.scale) * 128 + hp(c, k) / c.scale;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return hs_a;
      1:       return vs_b;
      default: return fs_b;
    endcase
  endfunction

  // Bounded wait (sampled on negedge) for a DUT output to reach a level.
  task automatic wait_for(input int w, input logic val, input int bound,
                          input string name, output int n_at);
    int g;
    g = 0;
    while (sig(w) !== val && g < bound) begin
      @(negedge clk);
      g++;
    end
    if (sig(w) !== val) begin
      checks++;
      failures++;
      $display("FAIL %s timeout after %0d clk", name, bound);
    end
    n_at = (w == 0) ? na : nb;
  endtask

  // Bounded wait until instance A has seen exactly t edges since release.
  task automatic wait_na(input int t);
    int g;
    g = 0;
    while (na < t && g < 2000000) begin
      @(negedge clk);
      g++;
    end
    if (na != t) chk("wait_na", na, t);
  endtask

  task automatic wait_nb(input int t);
    int g;
    g = 0;
    while (nb < t && g < 2000000) begin
      @(negedge clk);
      g++;
    end
    if (nb != t) chk("wait_nb", nb, t);
  endtask

  // Scoreboard for instance A: expectation queued when a position is
  // addressed, popped one tick later when it reaches the pins.
  exp_t q[$];
  always @(negedge clk) begin : sb_a
    int   a;
    exp_t e;
    if (!rst_a_n) begin
      q.delete();
    end else if (na >= 2 && (na % 2) == 0) begin
      a = na / 2 - 1;
      if (na >= 4) begin
        if (q.size() == 0) begin
          chk("sb_underflow", 0, 1);
        end else begin
          e = q.pop_front();
          chk("a_rgb", {vr_a, vg_a, vb_a}, e.rgb);
          chk("a_hsync", hs_a, e.hs);
          chk("a_vsync", vs_a, e.vs);
        end
      end else begin
        chk("a_rgb_first", {vr_a, vg_a, vb_a}, 0);
        chk("a_hsync_first", hs_a, 1);
      end
      e.rgb = vis(ca, a) ? {(adr(ca, a) == 0), 2'b00} : 3'b000;
      e.hs  = hsr(ca, a);
      e.vs  = vsr(ca, a);
      q.push_back(e);
      chk("a_en", en_a, vis(ca, a));
      if (vis(ca, a)) chk("a_addr", addr_a, adr(ca, a));
      chk("a_frame", fs_a, (a % (ht(ca) * vt(ca))) == 0);
    end else if (na >= 1) begin
      chk("a_frame_odd", fs_a, 0);
    end
  end

  // Direct model check for instance B: RAM all ones, so RGB is 111 exactly
  // on visible pixels and 000 in all blanking.
  always @(negedge clk) begin : sb_b
    int a;
    int j;
    if (rst_b_n && nb >= 4 && (nb % 2) == 0) begin
      a = nb / 2 - 1;
      j = nb / 2 - 2;
      chk("b_rgb", {vr_b, vg_b, vb_b}, vis(cb, j) ? 7 : 0);
      chk("b_hsync", hs_b, hsr(cb, j));
      chk("b_vsync", vs_b, vsr(cb, j));
      chk("b_en", en_b, vis(cb, a));
      if (vis(cb, a)) chk("b_addr", addr_b, adr(cb, a));
    end
  end

  vec_t tbl [12];

  initial begin
    int n0, n1, n2;
    ca = '{640, 16, 96, 48, 480, 10, 2, 33, 5};
    cb = '{128, 2, 4, 2, 96, 1, 2, 1, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", addr_a, 0);
    chk("rst_en", en_a, 0);
    chk("rst_we", we_a, 0);
    chk("rst_rgb", {vr_a, vg_a, vb_a}, 0);
    chk("rst_hsync", hs_a, 1);
    chk("rst_vsync", vs_a, 1);
    chk("rst_frame", fs_a, 0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    fork
      // horizontal sync timing on instance A
      begin
        wait_for(0, 1'b0, 3000, "hs_fall1", n0);
        chk("hs_first_fall_after_tick", n0 - 2, 1314);
        wait_for(0, 1'b1, 3000, "hs_rise", n1);
        chk("hs_low_width", n1 - n0, 192);
        wait_for(0, 1'b0, 3000, "hs_fall2", n2);
        chk("hs_period", n2 - n0, 1600);
      end
      // address scan table, then mid-line reset on instance A
      begin
        tbl[0]  = '{0,   0, 0,   1'b1};
        tbl[1]  = '{4,   0, 0,   1'b1};
        tbl[2]  = '{5,   0, 1,   1'b1};
        tbl[3]  = '{635, 0, 127, 1'b1};
        tbl[4]  = '{639, 0, 127, 1'b1};
        tbl[5]  = '{640, 0, 0,   1'b0};
        tbl[6]  = '{799, 0, 0,   1'b0};
        tbl[7]  = '{0,   1, 0,   1'b1};
        tbl[8]  = '{0,   5, 128, 1'b1};
        tbl[9]  = '{12,  5, 130, 1'b1};
        tbl[10] = '{639, 5, 255, 1'b1};
        tbl[11] = '{700, 5, 0,   1'b0};
        for (int i = 0; i < 12; i++) begin
          wait_na(2 * (tbl[i].v * 800 + tbl[i].h + 1));
          chk($sformatf("tbl%0d_en", i), en_a, tbl[i].en);
          if (tbl[i].en) chk($sformatf("tbl%0d_addr", i), addr_a, tbl[i].addr);
        end

        // asynchronous reset between edges at h=300 of line 6
        wait_na(2 * (6 * 800 + 300 + 1));
        chk("pre_rst_addr", addr_a, 188);
        #5 rst_a_n = 1'b0;
        #1;
        chk("mid_rst_addr", addr_a, 0);
        chk("mid_rst_en", en_a, 0);
        chk("mid_rst_rgb", {vr_a, vg_a, vb_a}, 0);
        chk("mid_rst_hsync", hs_a, 1);
        chk("mid_rst_vsync", vs_a, 1);
        chk("mid_rst_frame", fs_a, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a_n = 1'b1;
        wait_na(1);
        chk("post_rst_en_before_tick", en_a, 0);
        wait_na(2);
        chk("post_rst_addr0", addr_a, 0);
        chk("post_rst_frame", fs_a, 1);
        wait_na(12);
        chk("post_rst_addr1", addr_a, 1);
      end
      // vertical sync timing on instance B
      begin
        int m0, m1, m2;
        wait_for(1, 1'b0, 30000, "vs_fall1", m0);
        chk("vs_first_fall", m0, 2 * (97 * 136 + 2));
        wait_for(1, 1'b1, 30000, "vs_rise", m1);
        chk("vs_low_width", m1 - m0, 2 * 2 * 136);
        wait_for(1, 1'b0, 30000, "vs_fall2", m2);
        chk("vs_period", m2 - m0, 27200);
      end
      // frame start and last-pixel address on instance B
      begin
        int f0, f1, fx;
        wait_for(2, 1'b1, 10, "fs_first", f0);
        chk("fs_first_at", f0, 2);
        wait_for(2, 1'b0, 10, "fs_low", fx);
        chk("fs_width", fx - f0, 1);
        wait_nb(2 * (95 * 136 + 127 + 1));
        chk("b_last_addr", addr_b, 12287);
        chk("b_last_en", en_b, 1);
        wait_nb(2 * (95 * 136 + 128 + 1));
        chk("b_blank_en", en_b, 0);
        wait_for(2, 1'b1, 30000, "fs_second", f1);
        chk("fs_period", f1 - f0, 27200);
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
